// File: rtl/serial_adder_host.sv
// Word-level host for an LSB-first Mealy serial adder: accepts parallel operands,
// clears the adder carry, streams operand bits out and reassembles the sum.
module serial_adder_host #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             sa_rst,
    output logic             a_bit,
    output logic             b_bit,
    input  logic             sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        FIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             accept;
    logic             last;

    assign accept = in_valid && (state == IDLE);
    assign last   = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sa_rst also follows rst_n directly so the adder is cleared while the host is held in reset
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        sa_rst    = !rst_n;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CLR;
            end
            CLR: begin
                sa_rst    = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // a_bit/b_bit are preloaded on the CLR edge so each SHIFT cycle presents its bit from a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            a_bit     <= 1'b0;
            b_bit     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            case (state)
                CLR: begin
                    count <= '0;
                    a_bit <= a_sh[0];
                    b_bit <= b_sh[0];
                end
                SHIFT: begin
                    count <= count + CNT_W'(1);
                    a_bit <= last ? 1'b0 : a_sh[0];
                    b_bit <= last ? 1'b0 : b_sh[0];
                end
                FIN: begin
                    out_sum   <= sum_sh;
                    out_carry <= sum;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh   <= in_a;
            b_sh   <= in_b;
            sum_sh <= '0;
        end else if (state == CLR || state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
        end
        if (state == SHIFT) begin
            sum_sh <= {sum, sum_sh[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_serial_adder_host.sv
// Bench for serial_adder_host with a behavioural Mealy serial adder attached;
// results are checked against a scoreboard of operand sums.
module tb_serial_adder_host;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_ready;
    logic             sa_rst;
    logic             a_bit;
    logic             b_bit;
    logic             sum;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             carry;

    int               n_assert = 0;
    int               n_fail = 0;
    logic [WIDTH:0]   sb[$];

    always #5 clk = ~clk;

    serial_adder_host #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .sa_rst    (sa_rst),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    // Behavioural LSB-first Mealy serial adder
    always_ff @(posedge clk) begin
        if (sa_rst) carry <= 1'b0;
        else        carry <= (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    end
    assign sum = a_bit ^ b_bit ^ carry;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge with the host expected to be idle or busy.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int stall, input bit busy);
        int             cyc;
        logic [WIDTH-1:0] ab;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0] exp;
        logic [WIDTH:0] hold;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk("accept_wait", (cyc < 50) ? 1 : 0, 1);
        @(posedge clk);
        sb.push_back({1'b0, a} + {1'b0, b});
        #1;
        in_valid = 1'b0;
        chk("clr_sa_rst", sa_rst, 1);
        chk("clr_bits", {a_bit, b_bit}, 0);
        cyc = 0;
        ab = '0;
        bb = '0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
            if (cyc <= WIDTH) begin
                ab[cyc-1] = a_bit;
                bb[cyc-1] = b_bit;
                chk("shift_sa_rst", sa_rst, 0);
            end
            if (busy && cyc == 2) begin
                in_a = 4'hF;
                in_b = 4'h1;
                in_valid = 1'b1;
            end
            if (busy && cyc == 3) chk("busy_in_ready", in_ready, 0);
        end
        chk("latency", cyc, WIDTH + 2);
        chk("a_bit_seq", ab, a);
        chk("b_bit_seq", bb, b);
        exp = sb.pop_front();
        if (out_valid) begin
            hold = {out_carry, out_sum};
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_carry, out_sum}, hold);
                chk("stall_in_ready", in_ready, 0);
            end
            chk("result", {out_carry, out_sum}, exp);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("post_valid", out_valid, 0);
            chk("post_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_sa_rst", sa_rst, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", {out_carry, out_sum}, 0);
        chk("rst_bits", {a_bit, b_bit}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_sa_rst", sa_rst, 0);
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Basic add
        run_op(4'b1011, 4'b1101, 0, 1'b0);
        // Zero and max back-to-back
        run_op(4'd0, 4'd0, 0, 1'b0);
        run_op(4'd15, 4'd15, 0, 1'b0);
        run_op(4'd0, 4'd0, 0, 1'b0);
        // Backpressure
        run_op(4'd6, 4'd7, 5, 1'b0);
        // Busy ignore: F+1 presented during SHIFT of 9+6, consumed afterwards
        run_op(4'd9, 4'd6, 0, 1'b1);
        run_op(4'hF, 4'h1, 0, 1'b0);
        run_op(4'd5, 4'd9, 0, 1'b0);

        // Async reset in the 2nd SHIFT cycle
        in_a = 4'd7;
        in_b = 4'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_shift_a_bit", a_bit, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_sa_rst", sa_rst, 1);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out", {out_carry, out_sum}, 0);
        chk("arst_bits", {a_bit, b_bit}, 0);
        @(posedge clk); #1;
        chk("arst_hold_sa_rst", sa_rst, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("arst_no_result", out_valid, 0);
        end
        run_op(4'd3, 4'd5, 0, 1'b0);

        // Exhaustive sweep with random backpressure
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), int'($urandom_range(0, 2)), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
